// File: rtl/idli_cmp_m.sv
// Bit-serial compare unit feeding the predicate register file: consumes two
// operands LSB slice first, then issues a one-cycle registered predicate write.
module idli_cmp_m #(
    parameter int DATA_W  = 16,
    parameter int SLICE_W = 4
) (
    input  logic               i_cmp_gck,
    input  logic               i_cmp_rst,
    input  logic               i_cmp_start,
    input  logic               i_cmp_vld,
    input  logic [2:0]         i_cmp_op,
    input  logic [1:0]         i_cmp_dst,
    input  logic [SLICE_W-1:0] i_cmp_a,
    input  logic [SLICE_W-1:0] i_cmp_b,
    output logic               o_cmp_busy,
    output logic [1:0]         o_pred_wr,
    output logic               o_pred_wr_en,
    output logic               o_pred_wr_data
);

    localparam int N     = DATA_W / SLICE_W;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_WB   = 2'd2;

    localparam logic [2:0] OP_EQ  = 3'b000;
    localparam logic [2:0] OP_NE  = 3'b001;
    localparam logic [2:0] OP_LT  = 3'b010;
    localparam logic [2:0] OP_LTU = 3'b011;
    localparam logic [2:0] OP_GE  = 3'b100;
    localparam logic [2:0] OP_GEU = 3'b101;

    localparam logic [1:0] PREG_PT = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [1:0]       dst_q, dst_d;
    logic             carry_q, carry_d;
    logic             eq_q, eq_d;
    logic [1:0]       wr_q, wr_d;
    logic             wr_en_q, wr_en_d;
    logic             wr_data_q, wr_data_d;

    logic               accept;
    logic [CNT_W-1:0]   idx;
    logic               cin;
    logic [2:0]         cur_op;
    logic [1:0]         cur_dst;
    logic [SLICE_W-1:0] b_inv;
    logic [SLICE_W:0]   sum;
    logic               cout;
    logic               msb;
    logic               ov;
    logic               eq_run;
    logic               result;
    logic               suppress;

    // Datapath for the slice on the inputs this cycle; start restarts the
    // subtract chain with carry-in 1 regardless of what was in flight.
    always_comb begin
        accept  = i_cmp_start | (i_cmp_vld & (state_q == ST_RUN));
        idx     = i_cmp_start ? '0 : cnt_q;
        cin     = i_cmp_start ? 1'b1 : carry_q;
        cur_op  = i_cmp_start ? i_cmp_op : op_q;
        cur_dst = i_cmp_start ? i_cmp_dst : dst_q;
        b_inv   = ~i_cmp_b;
        sum     = {1'b0, i_cmp_a} + {1'b0, b_inv} + {{SLICE_W{1'b0}}, cin};
        cout    = sum[SLICE_W];
        msb     = sum[SLICE_W-1];
        // Carry into the MSB falls out of the MSB sum bit and its two addends.
        ov      = (msb ^ i_cmp_a[SLICE_W-1] ^ b_inv[SLICE_W-1]) ^ cout;
        eq_run  = (i_cmp_a == i_cmp_b) & (i_cmp_start | eq_q);

        case (cur_op)
            OP_EQ:   result = eq_run;
            OP_NE:   result = ~eq_run;
            OP_LT:   result = msb ^ ov;
            OP_LTU:  result = ~cout;
            OP_GE:   result = ~(msb ^ ov);
            OP_GEU:  result = cout;
            default: result = 1'b0;
        endcase
        suppress = (cur_dst == PREG_PT) | (cur_op > OP_GEU);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        dst_d     = dst_q;
        carry_d   = carry_q;
        eq_d      = eq_q;
        wr_d      = wr_q;
        wr_en_d   = 1'b0;
        wr_data_d = wr_data_q;

        if (accept) begin
            op_d    = cur_op;
            dst_d   = cur_dst;
            carry_d = cout;
            eq_d    = eq_run;
            if (idx == LAST) begin
                state_d = ST_WB;
                cnt_d   = '0;
                if (!suppress) begin
                    wr_en_d   = 1'b1;
                    wr_d      = cur_dst;
                    wr_data_d = result;
                end
            end else begin
                state_d = ST_RUN;
                cnt_d   = idx + CNT_W'(1);
            end
        end else if (state_q == ST_WB) begin
            state_d = ST_IDLE;
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples the
    // pre-edge values; reset is synchronous, so it sits inside the clocked branch.
    always_ff @(posedge i_cmp_gck) begin
        if (i_cmp_rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            dst_q     <= '0;
            carry_q   <= 1'b0;
            eq_q      <= 1'b0;
            wr_q      <= '0;
            wr_en_q   <= 1'b0;
            wr_data_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            dst_q     <= dst_d;
            carry_q   <= carry_d;
            eq_q      <= eq_d;
            wr_q      <= wr_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign o_cmp_busy     = (state_q == ST_RUN);
    assign o_pred_wr      = wr_q;
    assign o_pred_wr_en   = wr_en_q;
    assign o_pred_wr_data = wr_data_q;

endmodule

// File: tb/tb_idli_cmp_m.sv
// Scoreboard bench for idli_cmp_m: the driver pushes expected predicate writes
// computed from whole-operand arithmetic; a negedge monitor pops and compares.
module tb_idli_cmp_m;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       vld;
    logic [2:0] op;
    logic [1:0] dst;
    logic [3:0] a_s;
    logic [3:0] b_s;
    logic       busy;
    logic [1:0] pred_wr;
    logic       pred_wr_en;
    logic       pred_wr_data;

    always #5 clk = ~clk;

    idli_cmp_m #(.DATA_W(16), .SLICE_W(4)) dut (
        .i_cmp_gck     (clk),
        .i_cmp_rst     (rst),
        .i_cmp_start   (start),
        .i_cmp_vld     (vld),
        .i_cmp_op      (op),
        .i_cmp_dst     (dst),
        .i_cmp_a       (a_s),
        .i_cmp_b       (b_s),
        .o_cmp_busy    (busy),
        .o_pred_wr     (pred_wr),
        .o_pred_wr_en  (pred_wr_en),
        .o_pred_wr_data(pred_wr_data)
    );

    typedef struct {
        int       cyc;
        logic [1:0] dst;
        logic       data;
    } exp_t;

    exp_t       sb_q[$];
    int         checks   = 0;
    int         errors   = 0;
    int         edge_cnt = 0;
    bit         mon_en   = 1'b0;
    logic       exp_busy = 1'b0;
    logic [1:0] exp_wr   = 2'd0;
    logic       exp_data = 1'b0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    function automatic logic ref_result(input logic [2:0] f_op, input logic [15:0] a, input logic [15:0] b);
        case (f_op)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd2:    return $signed(a) < $signed(b);
            3'd3:    return a < b;
            3'd4:    return $signed(a) >= $signed(b);
            3'd5:    return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            check("busy", {31'd0, busy}, {31'd0, exp_busy});
            check("pred_wr", {30'd0, pred_wr}, {30'd0, exp_wr});
            check("pred_wr_data", {31'd0, pred_wr_data}, {31'd0, exp_data});
            if (pred_wr_en) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_wr_en", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("wr_cycle", edge_cnt, e.cyc);
                    check("wr_dst", {30'd0, pred_wr}, {30'd0, e.dst});
                    check("wr_val", {31'd0, pred_wr_data}, {31'd0, e.data});
                end
            end else if (sb_q.size() > 0 && sb_q[0].cyc <= edge_cnt) begin
                check("missing_wr_en", 32'd0, 32'd1);
                void'(sb_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic slice(input bit s, input logic [2:0] s_op, input logic [1:0] s_dst,
                         input logic [3:0] sa, input logic [3:0] sb);
        start = s;
        vld   = 1'b1;
        // op/dst are only meaningful on start; scramble them otherwise
        op    = s ? s_op : 3'($urandom);
        dst   = s ? s_dst : 2'($urandom);
        a_s   = sa;
        b_s   = sb;
        tick();
        start = 1'b0;
        vld   = 1'b0;
        a_s   = 4'($urandom);
        b_s   = 4'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    // Valid slices without start while not running must be ignored.
    task automatic junk(input int n);
        repeat (n) begin
            vld = 1'b1;
            a_s = 4'($urandom);
            b_s = 4'($urandom);
            op  = 3'($urandom);
            dst = 2'($urandom);
            tick();
        end
        vld = 1'b0;
    endtask

    task automatic run_op(input logic [2:0] r_op, input logic [1:0] r_dst,
                          input logic [15:0] a, input logic [15:0] b,
                          input int stall, input int nslices);
        for (int i = 0; i < nslices; i++) begin
            if (i > 0) idle(stall);
            slice(i == 0, r_op, r_dst, a[4*i +: 4], b[4*i +: 4]);
            if (i < 3) begin
                exp_busy = 1'b1;
            end else begin
                exp_busy = 1'b0;
                if (r_dst != 2'd3 && r_op <= 3'd5) begin
                    exp_t e;
                    e.cyc  = edge_cnt;
                    e.dst  = r_dst;
                    e.data = ref_result(r_op, a, b);
                    sb_q.push_back(e);
                    exp_wr   = r_dst;
                    exp_data = e.data;
                end
            end
        end
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        start = 1'b0;
        vld   = 1'b0;
        tick();
        rst      = 1'b0;
        exp_busy = 1'b0;
        exp_wr   = 2'd0;
        exp_data = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        vld   = 1'b0;
        op    = 3'd0;
        dst   = 2'd0;
        a_s   = 4'd0;
        b_s   = 4'd0;
        idle(2);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_wr_en", {31'd0, pred_wr_en}, 32'd0);
        check("rst_wr", {30'd0, pred_wr}, 32'd0);
        check("rst_wr_data", {31'd0, pred_wr_data}, 32'd0);
        rst    = 1'b0;
        mon_en = 1'b1;

        // equality, equal and differing operands
        run_op(3'd0, 2'd1, 16'h1234, 16'h1234, 0, 4);
        idle(1);
        run_op(3'd0, 2'd1, 16'h1234, 16'h1235, 0, 4);
        idle(1);
        // signed vs unsigned ordering at the sign boundary
        run_op(3'd2, 2'd2, 16'h8000, 16'h0001, 0, 4);
        run_op(3'd3, 2'd2, 16'h8000, 16'h0001, 0, 4);
        run_op(3'd4, 2'd0, 16'h7FFF, 16'h8000, 0, 4);
        idle(1);
        // stalls between every slice
        run_op(3'd5, 2'd1, 16'hFFFF, 16'hFFFF, 2, 4);
        junk(2);
        // suppressed writes: PREG_PT destination and reserved op
        run_op(3'd0, 2'd3, 16'h5555, 16'h5555, 0, 4);
        run_op(3'd6, 2'd0, 16'h0000, 16'h0000, 0, 4);
        idle(2);
        // reset mid-operation, then a fresh compare
        run_op(3'd1, 2'd0, 16'hABCD, 16'h1234, 0, 3);
        do_reset();
        run_op(3'd0, 2'd2, 16'h0000, 16'h0000, 0, 4);
        idle(2);
        // back-to-back start in the write-back cycle
        run_op(3'd0, 2'd0, 16'h4242, 16'h4242, 0, 4);
        run_op(3'd3, 2'd2, 16'h0001, 16'h0002, 0, 4);
        idle(2);
        // restart mid-operation aborts the first compare
        run_op(3'd0, 2'd1, 16'h4242, 16'h4242, 0, 2);
        run_op(3'd3, 2'd2, 16'h0001, 16'h0002, 0, 4);
        idle(2);

        for (int n = 0; n < 300; n++) begin
            int       kind;
            logic [15:0] ra;
            logic [15:0] rb;
            kind = $urandom_range(0, 9);
            ra   = 16'($urandom);
            rb   = ($urandom_range(0, 3) == 0) ? ra : 16'($urandom);
            if (kind == 0) begin
                run_op(3'($urandom), 2'($urandom), ra, rb, $urandom_range(0, 2), $urandom_range(1, 3));
                if ($urandom_range(0, 1) == 0) do_reset();
            end else begin
                run_op(3'($urandom), 2'($urandom), ra, rb, $urandom_range(0, 2), 4);
                if (kind == 1) junk($urandom_range(1, 3));
                else if (kind == 2) idle($urandom_range(1, 2));
            end
        end

        idle(4);
        check("scoreboard_empty", sb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
